// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The overflow flag of bin_to_bcd_seq is enabled with the BIN2BCD_OVF_EN macro.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_VAL    = 4'd3;

    // Plain 2-bit encoding so the state register stays legacy-tool friendly
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_VAL : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential WIDTH-bit binary to NDIG-digit packed BCD converter, one bit per clock.
// Define BIN2BCD_OVF_EN to add the sticky ovf output (input exceeded 10^NDIG-1).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BCD_DIGIT_W*NDIG-1:0] out_bcd,
    output logic                       busy
`ifdef BIN2BCD_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * NDIG;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               release_res;

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SHIFT);
    assign out_valid   = (state_q == ST_DONE);
    assign out_bcd     = bcd_q;
    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_add3 u_add3 (
            .digit_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BIN2BCD_OVF_EN
    // Keep one extra bit on top so the bit leaving the top digit can be observed
    logic [BCD_W+WIDTH:0] shifted;
    logic                 carry_out;
    assign shifted   = {bcd_adj, shift_q, 1'b0};
    assign carry_out = shifted[BCD_W+WIDTH];
`else
    logic [BCD_W+WIDTH-1:0] shifted;
    assign shifted = {bcd_adj, shift_q} << 1;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = in_bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = shifted[BCD_W+WIDTH-1:WIDTH];
                shift_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (release_res) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BIN2BCD_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            ovf_d = ovf_q | carry_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int WIDTH = 8;
    localparam int NDIG  = 3;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_bin;
    logic [11:0] out_bcd;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0]  in_bin2;
    logic [7:0]  out_bcd2;
`ifdef BIN2BCD_OVF_EN
    logic        ovf, ovf2;
`endif

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
`ifdef BIN2BCD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    bin_to_bcd_seq #(.WIDTH(8), .NDIG(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_bin    (in_bin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_bcd   (out_bcd2),
        .busy      (busy2)
`ifdef BIN2BCD_OVF_EN
        ,
        .ovf       (ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decimal digits straight from division/modulo, packed units-first
    function automatic logic [11:0] modelBcd(input int value, input int nd);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd && i < 3; i++) begin
            r[i*4 +: 4] = 4'((value / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int value, input int stallCycles, input int newBin);
        int n;
        int busyCnt;
        logic [11:0] exp;
        exp = modelBcd(value, NDIG);
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        checkOutput("ready_before_accept", 32'(in_ready), 1);
        in_bin   = 8'(value);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_bin   = 8'(newBin);
        checkOutput("ready_low_in_shift", 32'(in_ready), 0);
        n = 0;
        busyCnt = 0;
        while (!out_valid && n < 100) begin
            if (busy) busyCnt++;
            step();
            n++;
        end
        checkOutput("latency", n, WIDTH);
        checkOutput("busy_cycles", busyCnt, WIDTH);
        checkOutput("result", 32'(out_bcd), 32'(exp));
        checkOutput("busy_low_done", 32'(busy), 0);
        for (int i = 0; i < stallCycles; i++) begin
            step();
            checkOutput("stall_valid", 32'(out_valid), 1);
            checkOutput("stall_bcd", 32'(out_bcd), 32'(exp));
            checkOutput("stall_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("idle_ready", 32'(in_ready), 1);
        checkOutput("idle_valid", 32'(out_valid), 0);
        checkOutput("idle_keeps_result", 32'(out_bcd), 32'(exp));
    endtask

    task automatic applyStimulus2(input int value);
        int n;
        logic [11:0] exp;
        exp = modelBcd(value, 2);
        in_bin2   = 8'(value);
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 100) begin
            step();
            n++;
        end
        checkOutput("ndig2_latency", n, 8);
        checkOutput("ndig2_result", 32'(out_bcd2), 32'(exp[7:0]));
`ifdef BIN2BCD_OVF_EN
        checkOutput("ndig2_ovf", 32'(ovf2), 32'(value > 99));
`endif
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        checkOutput("ndig2_idle", 32'(in_ready2), 1);
    endtask

    int          vals[3];
    int          accCyc[3];
    logic [11:0] expq[$];
    int          idx, got;
    logic        acc, pop;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_bin = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_bin2 = '0;
        step();
        step();
        checkOutput("reset_in_ready", 32'(in_ready), 1);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_out_bcd", 32'(out_bcd), 0);
        checkOutput("reset_out_bcd2", 32'(out_bcd2), 0);
`ifdef BIN2BCD_OVF_EN
        checkOutput("reset_ovf", 32'(ovf), 0);
`endif
        rst = 1'b0;
        step();

        applyStimulus(255, 0, 0);
        applyStimulus(137, 5, 3);
        applyStimulus(42, 0, 99);

        // Back-to-back: in_valid and out_ready held high the whole time
        vals = '{0, 9, 100};
        idx = 0;
        got = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bin    = 8'(vals[0]);
        for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                checkOutput("b2b_pending", 32'(expq.size() > 0), 1);
                if (expq.size() > 0) checkOutput("b2b_result", 32'(out_bcd), 32'(expq.pop_front()));
                got++;
            end
            if (busy || out_valid) checkOutput("b2b_ready_low", 32'(in_ready), 0);
            if (acc) begin
                expq.push_back(modelBcd(vals[idx], NDIG));
                accCyc[idx] = cyc;
                if (idx > 0) checkOutput("b2b_interval", cyc - accCyc[idx-1], WIDTH + 2);
                idx++;
            end
            step();
            if (acc) begin
                if (idx < 3) in_bin = 8'(vals[idx]);
                else in_valid = 1'b0;
            end
        end
        checkOutput("b2b_count", got, 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        // Reset during the 4th SHIFT cycle abandons the conversion
        in_bin   = 8'd200;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        checkOutput("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mid_reset_ready", 32'(in_ready), 1);
        checkOutput("mid_reset_valid", 32'(out_valid), 0);
        checkOutput("mid_reset_bcd", 32'(out_bcd), 0);
        checkOutput("mid_reset_busy", 32'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("abandoned_no_valid", 32'(out_valid), 0);
        end
        applyStimulus(57, 0, 13);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)));
        end

        applyStimulus2(200);
        applyStimulus2(99);
        applyStimulus2(255);
        applyStimulus2(100);
        for (int i = 0; i < 6; i++) begin
            applyStimulus2(int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Generalises the single-digit decimal/BCD encoders to a WIDTH-bit binary input and an NDIG-digit packed BCD output.
- Uses valid/ready handshakes on both sides.
- Feeds display drivers and the decimal-formatting paths.

Parameters:
- WIDTH, 8, binary input width in bits; legal range ≥1.
- NDIG, 3, number of 4-bit BCD output digits; legal range ≥1; not required to cover 2^WIDTH-1.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_bin is valid.
- in_ready  output  1  block can accept in_bin.
- in_bin  input  WIDTH  unsigned binary value.
- out_valid  output  1  out_bcd holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_bcd  output  4*NDIG  packed BCD; digit 0 (units) in bits [3:0].
- busy  output  1  conversion in progress (state SHIFT).
- ovf  output  1  present only with BIN2BCD_OVF_EN; see Optional Feature.

Behaviour:
- Reset: synchronous, active-high. State IDLE, shift and BCD registers 0, bit counter 0. Outputs: in_ready=1, out_valid=0, busy=0, out_bcd=0, ovf=0.
- Reset mid-conversion or in DONE: the conversion is abandoned and the result is never presented.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: load in_bin into the shift register, clear the BCD register and counter, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge, every digit ≥5 gets +3 (4-bit result). Then {bcd,shift} shifts left by 1, MSB of shift entering bcd bit 0. Counter increments.
  - After the WIDTH-th shift (edge k+WIDTH), go to DONE.
- DONE:
  - out_valid=1. out_bcd is stable until the handshake completes.
  - On out_valid&&out_ready, go to IDLE.
  - No new input is accepted in DONE, including on the handshake cycle.
- Timing:
  - Latency: out_valid first high in the cycle after edge k+WIDTH.
  - Minimum input-to-input interval is WIDTH+2 cycles.
- Handshake rules:
  - in_bin is sampled only on the accept edge; later changes are ignored.
  - in_valid while not ready is held off, not dropped by the block.
  - out_valid never drops without out_ready.
- out_bcd is driven from the BCD register and is meaningful only while out_valid=1. In IDLE it keeps the last result; it is 0 after reset.
- Overflow: bits shifted out of the top digit are discarded, so out_bcd = in_bin mod 10^NDIG.
- WIDTH=1: one shift cycle; result is 0 or 1.

Optional Feature:
- Macro: BIN2BCD_OVF_EN.
- Defined:
  - Adds the ovf output.
  - ovf is cleared on accept and set sticky if any 1 is shifted out of the top digit during SHIFT. This is equivalent to in_bin > 10^NDIG-1.
  - ovf is valid with out_valid and held with out_bcd.
  - Reset value 0.
- Undefined:
  - ovf port and its logic are absent.
  - Results silently wrap modulo 10^NDIG.

Decomposition:
- Shared package bcd_pkg:
  - state typedef (IDLE, SHIFT, DONE);
  - constants BCD_DIGIT_W=4 and BCD_ADJ_THRESH=5, BCD_ADJ_VAL=3.
- Sub-module bcd_add3: combinational 4-bit digit in, corrected digit out (+3 if ≥5). Instantiated NDIG times via generate.
- Counter width is $clog2(WIDTH+1), computed locally.

Test Plan:
- WIDTH=8, NDIG=3, in_bin=255 accepted at edge k, out_ready=1 → out_valid high after edge k+8; out_bcd=12'h255; busy high for exactly 8 cycles.
- in_bin=0, then in_bin=9, then in_bin=100, back-to-back with in_valid held high → results 12'h000, 12'h009, 12'h100 in order; each accept exactly 10 cycles apart; in_ready low during SHIFT/DONE.
- in_bin=137, out_ready held low for 5 cycles after out_valid → out_bcd=12'h137 and out_valid stay constant; in_ready=0 throughout; IDLE entered the cycle after out_ready=1.
- Change in_bin from 42 to 99 one cycle after the accept edge → result 12'h042.
- Assert rst at the 4th SHIFT cycle of in_bin=200 → next cycle in_ready=1, out_valid=0, out_bcd=0, busy=0; a fresh in_bin=57 converts to 12'h057.
- WIDTH=8, NDIG=2 with BIN2BCD_OVF_EN: in_bin=200 → out_bcd=8'h00, ovf=1; in_bin=99 → out_bcd=8'h99, ovf=0. Without the macro, the same 200 gives 8'h00 and no ovf port.
